fpmult_arbiter: RTL and testbench
=================================

Name: fpmult_arbiter

Overview:
- Shares one multi-cycle fpmult instance among NUM_CH requesters (e.g. oscillator and envelope voices) using round-robin arbitration.
- Per operation: restarts fpmult with a one-cycle synchronous reset, holds the operands stable, waits for done, then returns the product to the granted channel.
- Sits between the voice datapaths and the single shared fpmult in the DSP block.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- TIMEOUT, 15, maximum cycles in RUN before the operation is aborted.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  channel i has an operand pair pending.
- req_a  in  32*NUM_CH  channel i operand A at bits [32i+31:32i].
- req_b  in  32*NUM_CH  channel i operand B at bits [32i+31:32i].
- req_ready  out  NUM_CH  one-hot pulse: channel i's operands were captured this cycle.
- resp_valid  out  NUM_CH  one-hot pulse: resp_result belongs to channel i.
- resp_result  out  32  product, valid while any resp_valid bit is high.
- timeout_err  out  1  sticky flag: fpmult did not finish within TIMEOUT cycles.
- busy  out  1  high in any state other than IDLE.
- mult_reset  out  1  drives the fpmult synchronous active-high reset.
- mult_dataa  out  32  drives fpmult dataa.
- mult_datab  out  32  drives fpmult datab.
- mult_result  in  32  fpmult result.
- mult_done  in  1  fpmult done.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; mult_reset = 1.
  - req_ready, resp_valid, resp_result, mult_dataa, mult_datab = 0.
  - timeout_err = 0; round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- All outputs are registered. States: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - mult_reset = 1 (keeps fpmult parked with done = 0).
  - If any req_valid is set, grant the first set channel searching upward from pointer+1, wrapping modulo NUM_CH.
  - Latch that channel's req_a/req_b into mult_dataa/mult_datab, pulse its req_ready for one cycle, update pointer to the granted index, go to CLEAR.
- CLEAR:
  - One cycle with mult_reset = 1, so fpmult restarts at its step 0 with the new operands.
  - Go to RUN with mult_reset = 0 and the cycle counter cleared.
- RUN:
  - mult_reset = 0; mult_dataa/mult_datab held unchanged for the whole operation.
  - Counter increments every cycle.
  - When mult_done = 1: capture mult_result into resp_result, go to RESP.
  - If the counter reaches TIMEOUT first: set timeout_err, set resp_result = 0x7FC00000, go to RESP.
  - Expected latency is 2 cycles (zero operand), 3–4 cycles (underflow/overflow), 7 cycles (normal).
- RESP:
  - resp_valid[granted] = 1 for exactly one cycle; mult_reset = 1; go to IDLE.
  - resp_result holds its value until the next RESP.
- Request side:
  - A channel may drop req_valid at any time before its req_ready pulse with no effect.
  - After req_ready, the channel must not expect a second grant for the same data.
  - req_valid held high re-requests.
- Fairness: with all channels requesting continuously, grants go 0,1,…,NUM_CH-1,0,… One grant per operation; no back-to-back grant to the same channel while others wait.
- Throughput: a new grant occurs in the IDLE cycle after RESP. A normal operation occupies 10 cycles from grant to the next possible grant (IDLE, CLEAR, RUN×7, RESP).
- timeout_err is sticky and cleared only by reset_n.
- Asserting reset_n mid-operation:
  - Aborts immediately; no resp_valid is issued for the in-flight request.
  - mult_reset is forced to 1.
  - The requester must re-request after reset.
- mult_done is ignored outside RUN.

Test Plan:
- Single request: ch0 a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ready[0] pulse, resp_valid[0] after ~9 cycles, resp_result=0x40C00000 (6.0).
- Zero operand: ch2 a=0x00000000, b=0xC0000000 -> resp_valid[2], resp_result=0x80000000; RUN lasts ≤2 cycles.
- Round-robin: all 4 channels hold req_valid with distinct operands -> grant order 0,1,2,3,0; each resp_valid carries its own channel's correct product; no channel starved.
- Overflow/underflow: a=b=0x7F000000 -> resp_result=0x7F800000 (+inf); a=b=0x01000000 -> resp_result=0x00000000.
- Timeout: bench model holds mult_done=0 -> after TIMEOUT cycles timeout_err=1, resp_valid pulses with 0x7FC00000; the next request completes normally and timeout_err stays 1.
- Reset mid-op: drop reset_n during RUN -> all outputs return to reset values asynchronously, mult_reset=1, no resp_valid; after release, ch0 wins first grant.

Source files
------------

// File: rtl/fpmult_arbiter.sv
// Round-robin front end that time-shares one multi-cycle fpmult between NUM_CH
// requesters: restart the multiplier, hold operands, wait for done, route the product back.
module fpmult_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CH-1:0]      req_valid,
    input  logic [32*NUM_CH-1:0]   req_a,
    input  logic [32*NUM_CH-1:0]   req_b,
    output logic [NUM_CH-1:0]      req_ready,
    output logic [NUM_CH-1:0]      resp_valid,
    output logic [31:0]            resp_result,
    output logic                   timeout_err,
    output logic                   busy,
    output logic                   mult_reset,
    output logic [31:0]            mult_dataa,
    output logic [31:0]            mult_datab,
    input  logic [31:0]            mult_result,
    input  logic                   mult_done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [SUM_W-1:0]  NCH      = SUM_W'(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_CH-1:0] OH_ONE   = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_CH-1:0]   gnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   req_ready_q;
    logic [NUM_CH-1:0]   resp_valid_q;
    logic [31:0]         resp_result_q;
    logic                timeout_err_q;
    logic                busy_q;
    logic                mult_reset_q;
    logic [31:0]         mult_dataa_q;
    logic [31:0]         mult_datab_q;

    logic                gnt_found_d;
    logic [IDX_W-1:0]    gnt_idx_d;
    logic [SUM_W-1:0]    cand_sum;
    logic [NUM_CH-1:0]   gnt_oh_d;

    // Search upward from the channel after the last winner, wrapping modulo NUM_CH.
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        cand_sum    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (cand_sum >= NCH) begin
                cand_sum = cand_sum - NCH;
            end
            if (!gnt_found_d && req_valid[cand_sum[IDX_W-1:0]]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = cand_sum[IDX_W-1:0];
            end
        end
    end

    assign gnt_oh_d = OH_ONE << gnt_idx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(NUM_CH - 1);
            gnt_q         <= '0;
            cnt_q         <= '0;
            req_ready_q   <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            mult_reset_q  <= 1'b1;
            mult_dataa_q  <= '0;
            mult_datab_q  <= '0;
        end else begin
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    mult_reset_q <= 1'b1;
                    if (gnt_found_d) begin
                        mult_dataa_q <= req_a[{gnt_idx_d, 5'd0} +: 32];
                        mult_datab_q <= req_b[{gnt_idx_d, 5'd0} +: 32];
                        req_ready_q  <= gnt_oh_d;
                        gnt_q        <= gnt_oh_d;
                        ptr_q        <= gnt_idx_d;
                        busy_q       <= 1'b1;
                        state_q      <= CLEAR;
                    end
                end
                CLEAR: begin
                    mult_reset_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A finishing multiplier wins over a timeout landing on the same cycle.
                    if (mult_done) begin
                        resp_result_q <= mult_result;
                        resp_valid_q  <= gnt_q;
                        mult_reset_q  <= 1'b1;
                        state_q       <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        resp_result_q <= QNAN;
                        timeout_err_q <= 1'b1;
                        resp_valid_q  <= gnt_q;
                        mult_reset_q  <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    mult_reset_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign mult_reset  = mult_reset_q;
    assign mult_dataa  = mult_dataa_q;
    assign mult_datab  = mult_datab_q;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Bench for fpmult_arbiter: behavioural fpmult stand-in, directed vector table,
// mid-operation reset, round-robin order and a randomized run against a transaction model.
module tb_fpmult_arbiter;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NUM_CH-1:0]    req_valid;
    logic [32*NUM_CH-1:0] req_a;
    logic [32*NUM_CH-1:0] req_b;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    resp_valid;
    logic [31:0]          resp_result;
    logic                 timeout_err;
    logic                 busy;
    logic                 mult_reset;
    logic [31:0]          mult_dataa;
    logic [31:0]          mult_datab;
    logic [31:0]          mult_result;
    logic                 mult_done;

    always #5 clk = ~clk;

    fpmult_arbiter #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
        .timeout_err(timeout_err), .busy(busy), .mult_reset(mult_reset),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab),
        .mult_result(mult_result), .mult_done(mult_done)
    );

    // Truncating single-precision multiply; zero, overflow and underflow handled explicitly.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    function automatic int fp_lat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 2;
        r = fp_mul(a, b);
        if (r[30:23] == 8'hFF || r[30:0] == 31'd0) return 3;
        return 7;
    endfunction

    // fpmult stand-in: counts cycles out of reset, done after its operand-dependent latency.
    logic hang = 1'b0;
    logic glitch = 1'b0;
    int   step = 0;
    always @(posedge clk) begin
        if (mult_reset) step <= 0;
        else            step <= step + 1;
    end
    assign mult_done   = (mult_reset && glitch) ||
                         (!mult_reset && !hang && step >= fp_lat(mult_dataa, mult_datab) - 1);
    assign mult_result = fp_mul(mult_dataa, mult_datab);

    // Requester side
    logic [31:0] op_a [NUM_CH];
    logic [31:0] op_b [NUM_CH];
    logic [31:0] op_exp [NUM_CH];
    bit          op_hang [NUM_CH];
    bit          has_op [NUM_CH];
    bit          rereq = 1'b0;
    bit          rnd_mode = 1'b0;

    // Transaction model of the arbiter
    int                m_ptr = NUM_CH - 1;
    bit                m_active = 1'b0;
    int                m_rem = 0;
    int                m_lat = 0;
    int                m_ch = 0;
    logic [31:0]       m_a, m_b, m_res;
    bit                m_hang = 1'b0;
    logic [31:0]       m_last = 32'd0;
    bit                m_terr = 1'b0;
    bit                m_idle_prev = 1'b0;
    logic [NUM_CH-1:0] m_valid_prev = '0;
    int                grants[$];
    int                n_resp = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_CH-1:0] v, input int p);
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (p + k) % NUM_CH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = has_op[i] && !(rnd_mode && ($urandom % 4 == 0));
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end
        if (!reset_n) v = '0;
        req_valid    = v;
        m_valid_prev = v;
        glitch       = rnd_mode && ($urandom % 3 == 0);
        hang         = m_active && m_hang;
    endtask

    // One clock: check this cycle's outputs against the model, then drive the next inputs.
    task automatic cycle();
        logic [NUM_CH-1:0] exp_ready, exp_resp;
        bit idle_now;
        int g;
        @(negedge clk);
        exp_ready = '0;
        exp_resp  = '0;
        if (m_idle_prev && m_valid_prev != '0) begin
            g = pick(m_valid_prev, m_ptr);
            exp_ready[g] = 1'b1;
            m_ptr    = g;
            m_ch     = g;
            m_active = 1'b1;
            m_a      = op_a[g];
            m_b      = op_b[g];
            m_hang   = op_hang[g];
            m_lat    = m_hang ? TIMEOUT : fp_lat(m_a, m_b);
            m_res    = m_hang ? 32'h7FC0_0000 : op_exp[g];
            m_rem    = m_lat + 1;
            grants.push_back(g);
            has_op[g] = rereq;
        end else if (m_active) begin
            m_rem--;
        end
        if (m_active && m_rem == 0) begin
            exp_resp[m_ch] = 1'b1;
            m_last = m_res;
            if (m_hang) m_terr = 1'b1;
        end
        idle_now = !m_active;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
        chk("resp_result", resp_result, m_last);
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("busy", 32'(busy), 32'(!idle_now));
        chk("mult_reset", 32'(mult_reset), 32'(!(m_active && m_rem >= 1 && m_rem <= m_lat)));
        if (m_active) begin
            chk("mult_dataa", mult_dataa, m_a);
            chk("mult_datab", mult_datab, m_b);
        end
        if (m_active && m_rem == 0) begin
            m_active = 1'b0;
            n_resp++;
        end
        m_idle_prev = idle_now && reset_n;
        drive();
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr    = NUM_CH - 1;
        m_last   = 32'd0;
        m_terr   = 1'b0;
        m_hang   = 1'b0;
        m_idle_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) has_op[i] = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int budget);
        int start;
        int c;
        start = n_resp;
        c = 0;
        while (n_resp == start && c < budget) begin
            cycle();
            c++;
        end
        if (n_resp == start) chk(name, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rnd_operand(input int cat);
        logic [7:0] e;
        case (cat)
            0: e = 8'(100 + $urandom % 50);
            1: e = 8'd0;
            2: e = 8'(200 + $urandom % 55);
            default: e = 8'(1 + $urandom % 30);
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    typedef struct {
        int          ch;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          hang;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0};
        tbl[1] = '{2, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
        tbl[2] = '{3, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0};
        tbl[3] = '{1, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 1'b0};
        tbl[4] = '{1, 32'h4000_0000, 32'h4040_0000, 32'h7FC0_0000, 1'b1};
        tbl[5] = '{2, 32'h3F80_0000, 32'h4080_0000, 32'h4080_0000, 1'b0};

        for (int i = 0; i < NUM_CH; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_exp[i] = '0; op_hang[i] = 1'b0; has_op[i] = 1'b0;
        end
        req_valid = '0; req_a = '0; req_b = '0;
        #1 reset_n = 1'b0;
        model_reset();
        repeat (3) cycle();
        reset_n = 1'b1;

        // Directed vectors, one operation each
        for (int i = 0; i < 6; i++) begin
            op_a[tbl[i].ch]    = tbl[i].a;
            op_b[tbl[i].ch]    = tbl[i].b;
            op_exp[tbl[i].ch]  = tbl[i].exp;
            op_hang[tbl[i].ch] = tbl[i].hang;
            has_op[tbl[i].ch]  = 1'b1;
            wait_resp("vec_timeout", 40);
            chk("vec_result", resp_result, tbl[i].exp);
            op_hang[tbl[i].ch] = 1'b0;
        end
        chk("terr_sticky", 32'(timeout_err), 32'd1);

        // Reset while the multiplier is running
        op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000; op_exp[0] = 32'h40C0_0000;
        has_op[0] = 1'b1;
        for (int c = 0; c < 20 && !(m_active && m_rem == 4); c++) cycle();
        chk("reached_run", 32'(m_active && m_rem == 4), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mult_reset", 32'(mult_reset), 32'd1);
        chk("rst_dataa", mult_dataa, 32'd0);
        chk("rst_datab", mult_datab, 32'd0);
        model_reset();
        drive();
        repeat (3) cycle();
        reset_n = 1'b1;

        // All channels requesting continuously: order must be 0,1,2,3,0
        for (int i = 0; i < NUM_CH; i++) begin
            op_a[i] = 32'h4000_0000;
            op_b[i] = {1'b0, 8'(127 + i), 23'd0};
            op_exp[i] = fp_mul(op_a[i], op_b[i]);
            has_op[i] = 1'b1;
        end
        rereq = 1'b1;
        grants.delete();
        for (int c = 0; c < 80 && grants.size() < 5; c++) cycle();
        chk("rr_count", 32'(grants.size() >= 5), 32'd1);
        if (grants.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(grants[k]), 32'(k % NUM_CH));
        end
        rereq = 1'b0;
        for (int i = 0; i < NUM_CH; i++) has_op[i] = 1'b0;
        for (int c = 0; c < 40 && m_active; c++) cycle();

        // Randomized traffic with request drops and stray done pulses outside RUN
        rnd_mode = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!has_op[i] && ($urandom % 6 == 0)) begin
                    int cat;
                    cat = int'($urandom % 4);
                    op_a[i]   = rnd_operand(cat);
                    op_b[i]   = rnd_operand((cat == 1) ? 0 : cat);
                    op_exp[i] = fp_mul(op_a[i], op_b[i]);
                    op_hang[i] = 1'b0;
                    has_op[i] = 1'b1;
                end
            end
            cycle();
        end
        rnd_mode = 1'b0;
        for (int i = 0; i < NUM_CH; i++) has_op[i] = 1'b0;
        for (int c = 0; c < 40 && m_active; c++) cycle();
        chk("drained", 32'(m_active), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
